// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-file read stage with write-back bypass and pending-write scoreboard
module operand_fetch #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int ADDRW = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] regBus,
  input  logic [WIDTH-1:0]       ALUBus,
  input  logic [NREGS-1:0]       regEnable,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ADDRW-1:0]       rsrc,
  input  logic [ADDRW-1:0]       rdest,
  input  logic                   dest_write,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [WIDTH-1:0]       opA,
  output logic [WIDTH-1:0]       opB,
  output logic [ADDRW-1:0]       dest_out,
  output logic                   dest_write_out,
  output logic [15:0]            stall_count
);

  logic [NREGS-1:0] pending_q, pending_d, set_mask;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] opA_q, opB_q, rd_a, rd_b;
  logic [ADDRW-1:0] dest_q;
  logic             dest_write_q;
  logic [15:0]      stall_q, stall_d;
  logic             hazard, fire;

  // A write landing this edge both bypasses its data and resolves the hazard
  always_comb begin
    rd_a     = regEnable[rsrc]  ? ALUBus : regBus[WIDTH*rsrc  +: WIDTH];
    rd_b     = regEnable[rdest] ? ALUBus : regBus[WIDTH*rdest +: WIDTH];
    hazard   = (pending_q[rsrc]  & ~regEnable[rsrc]) |
               (pending_q[rdest] & ~regEnable[rdest]);
    issue_ready = ~reset & ~hazard & (~op_valid_q | op_ready);
    fire     = issue_valid & issue_ready;
    set_mask = '0;
    if (fire & dest_write) set_mask[rdest] = 1'b1;
    pending_d = (pending_q & ~regEnable) | set_mask;
    op_valid_d = op_valid_q;
    if (fire) op_valid_d = 1'b1;
    else if (op_ready) op_valid_d = 1'b0;
    stall_d = stall_q;
    if (issue_valid & hazard & (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      op_valid_q   <= 1'b0;
      opA_q        <= '0;
      opB_q        <= '0;
      dest_q       <= '0;
      dest_write_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      op_valid_q <= op_valid_d;
      stall_q    <= stall_d;
      if (fire) begin
        opA_q        <= rd_a;
        opB_q        <= rd_b;
        dest_q       <= rdest;
        dest_write_q <= dest_write;
      end
    end
  end

  assign op_valid       = op_valid_q;
  assign opA            = opA_q;
  assign opB            = opB_q;
  assign dest_out       = dest_q;
  assign dest_write_out = dest_write_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] regBus;
  logic [15:0]  ALUBus, regEnable;
  logic         issue_valid, issue_ready;
  logic [3:0]   rsrc, rdest;
  logic         dest_write, op_valid, op_ready;
  logic [15:0]  opA, opB;
  logic [3:0]   dest_out;
  logic         dest_write_out;
  logic [15:0]  stall_count;

  logic [15:0]  rf [16];

  bit           m_valid;
  logic [15:0]  m_opA, m_opB;
  logic [3:0]   m_dest;
  bit           m_dw;
  bit           m_pend [16];
  int           m_stall;
  int           tests, fails;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) regBus[i*16 +: 16] = rf[i];
  end

  operand_fetch dut (
    .clk(clk), .reset(reset), .regBus(regBus), .ALUBus(ALUBus), .regEnable(regEnable),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .rsrc(rsrc), .rdest(rdest),
    .dest_write(dest_write), .op_valid(op_valid), .op_ready(op_ready), .opA(opA), .opB(opB),
    .dest_out(dest_out), .dest_write_out(dest_write_out), .stall_count(stall_count)
  );

  function automatic bit model_hazard();
    return (m_pend[rsrc] && !regEnable[rsrc]) || (m_pend[rdest] && !regEnable[rdest]);
  endfunction

  function automatic bit model_ready();
    return !reset && !model_hazard() && (!m_valid || op_ready);
  endfunction

  function automatic logic [15:0] model_rd(input logic [3:0] a);
    return regEnable[a] ? ALUBus : rf[a];
  endfunction

  // Advances one clock edge and moves the model by the inputs present before it
  task automatic tick();
    bit haz, f, rst, iv, rdy, dw;
    logic [15:0] a, b, en, alu;
    logic [3:0] d;
    haz = model_hazard(); f = issue_valid && model_ready();
    a = model_rd(rsrc); b = model_rd(rdest);
    rst = reset; iv = issue_valid; rdy = op_ready; dw = dest_write;
    en = regEnable; alu = ALUBus; d = rdest;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) if (en[i]) rf[i] = alu;
    if (rst) begin
      m_valid = 0; m_opA = 0; m_opB = 0; m_dest = 0; m_dw = 0; m_stall = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (en[i]) m_pend[i] = 0;
      if (f && dw) m_pend[d] = 1;
      if (f) begin
        m_valid = 1; m_opA = a; m_opB = b; m_dest = d; m_dw = dw;
      end else if (rdy) m_valid = 0;
      if (iv && haz && m_stall < 65535) m_stall++;
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; rsrc = 0; rdest = 0; dest_write = 0; regEnable = 0; ALUBus = 0; op_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; issue_valid = 1; rsrc = 1; rdest = 2;
    #1;
    tests++;
    if (issue_ready !== 1'b0) begin
      fails++; $display("FAIL reset_issue_ready got=%b exp=0", issue_ready);
    end
    tick(); tick();
    tests++;
    if ({op_valid, opA, opB, dest_out, dest_write_out, stall_count} !== 54'd0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b a=%h b=%h d=%h dw=%b sc=%h exp all 0",
               op_valid, opA, opB, dest_out, dest_write_out, stall_count);
    end
    reset = 0; idle_inputs(); tick();
  endtask

  task automatic test_plain_read();
    rf[3] = 16'h1234; rf[5] = 16'hABCD;
    issue_valid = 1; rsrc = 3; rdest = 5; dest_write = 0; op_ready = 1;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL plain_issue_ready got=%b exp=1", issue_ready);
    end
    tick();
    idle_inputs();
    tests++;
    if ({op_valid, opA, opB, dest_out} !== {1'b1, 16'h1234, 16'hABCD, 4'd5}) begin
      fails++;
      $display("FAIL plain_read got v=%b a=%h b=%h d=%0d exp v=1 a=1234 b=abcd d=5",
               op_valid, opA, opB, dest_out);
    end
    tick();
  endtask

  task automatic test_bypass();
    rf[2] = 16'h0001;
    ALUBus = 16'h00FF; regEnable = 16'h0004;
    issue_valid = 1; rsrc = 2; rdest = 0; dest_write = 0;
    tick();
    idle_inputs();
    tests++;
    if (opA !== 16'h00FF || op_valid !== 1'b1) begin
      fails++; $display("FAIL bypass_opA got=%h v=%b exp=00ff v=1", opA, op_valid);
    end
    tick();
  endtask

  task automatic test_raw_stall();
    int s0;
    s0 = m_stall;
    issue_valid = 1; rsrc = 0; rdest = 7; dest_write = 1;
    tick();
    rsrc = 7; rdest = 1; dest_write = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (issue_ready !== 1'b0) begin
        fails++; $display("FAIL raw_stall_ready cycle=%0d got=%b exp=0", c, issue_ready);
      end
      tick();
    end
    tests++;
    if (stall_count !== 16'(s0 + 3)) begin
      fails++; $display("FAIL raw_stall_count got=%0d exp=%0d", stall_count, s0 + 3);
    end
    regEnable = 16'h0080; ALUBus = 16'h0042;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL raw_release_ready got=%b exp=1", issue_ready);
    end
    tick();
    tests++;
    if (opA !== 16'h0042 || op_valid !== 1'b1 || stall_count !== 16'(s0 + 3)) begin
      fails++;
      $display("FAIL raw_release got a=%h v=%b sc=%0d exp a=0042 v=1 sc=%0d", opA, op_valid, stall_count, s0 + 3);
    end
    regEnable = 0; ALUBus = 0;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL raw_pending_cleared got=%b exp=1", issue_ready);
    end
    tick();
    idle_inputs(); tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] a1, b1, a2, b2;
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    rf[1] = a1; rf[2] = b1; rf[4] = a2; rf[6] = b2;
    issue_valid = 1; rsrc = 1; rdest = 2; dest_write = 0; op_ready = 1;
    tick();
    op_ready = 0; rsrc = 4; rdest = 6; dest_write = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (issue_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", c, issue_ready);
      end
      tick();
      tests++;
      if ({op_valid, opA, opB, dest_out, dest_write_out} !== {1'b1, a1, b1, 4'd2, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold cycle=%0d got v=%b a=%h b=%h d=%0d exp v=1 a=%h b=%h d=2",
                 c, op_valid, opA, opB, dest_out, a1, b1);
      end
    end
    op_ready = 1;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release_ready got=%b exp=1", issue_ready);
    end
    tick();
    tests++;
    if ({op_valid, opA, opB, dest_out, dest_write_out} !== {1'b1, a2, b2, 4'd6, 1'b1}) begin
      fails++;
      $display("FAIL bp_release got v=%b a=%h b=%h d=%0d dw=%b exp v=1 a=%h b=%h d=6 dw=1",
               op_valid, opA, opB, dest_out, dest_write_out, a2, b2);
    end
    idle_inputs(); regEnable = 16'h0040; tick();
    regEnable = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0111);
    for (int k = 0; k < 8; k++) begin
      issue_valid = 1; rsrc = 4'(k); rdest = 4'(15 - k); dest_write = 0; op_ready = 1;
      #1;
      tests++;
      if (issue_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, issue_ready);
      end
      tick();
      tests++;
      if ({op_valid, opA, opB} !== {1'b1, 16'(k * 16'h0111), 16'((15 - k) * 16'h0111)}) begin
        fails++; $display("FAIL b2b_ops k=%0d got v=%b a=%h b=%h", k, op_valid, opA, opB);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) < 2);
      issue_valid = $urandom_range(0, 3) != 0;
      rsrc        = 4'($urandom); rdest = 4'($urandom);
      dest_write  = $urandom_range(0, 2) == 0;
      op_ready    = $urandom_range(0, 3) != 0;
      regEnable   = 16'($urandom & $urandom & $urandom);
      ALUBus      = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 15)] = 16'($urandom);
      #1;
      tests++;
      if (issue_ready !== model_ready()) begin
        fails++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, issue_ready, model_ready());
      end
      tick();
      tests++;
      if ({op_valid, opA, opB, dest_out, dest_write_out, stall_count} !==
          {m_valid, m_opA, m_opB, m_dest, m_dw, 16'(m_stall)}) begin
        fails++;
        $display("FAIL rand_outputs cycle=%0d got v=%b a=%h b=%h d=%0d dw=%b sc=%0d exp v=%b a=%h b=%h d=%0d dw=%b sc=%0d",
                 c, op_valid, opA, opB, dest_out, dest_write_out, stall_count,
                 m_valid, m_opA, m_opB, m_dest, m_dw, m_stall);
      end
    end
    reset = 0; idle_inputs(); tick();
  endtask

  task automatic test_saturation();
    reset = 1; idle_inputs(); tick();
    reset = 0;
    issue_valid = 1; rsrc = 0; rdest = 9; dest_write = 1;
    tick();
    rsrc = 9; rdest = 0; dest_write = 0;
    repeat (70000) @(posedge clk);
    #1;
    tests++;
    if (stall_count !== 16'hFFFF || issue_ready !== 1'b0) begin
      fails++; $display("FAIL saturation got sc=%h ready=%b exp sc=ffff ready=0", stall_count, issue_ready);
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 16; i++) begin rf[i] = 0; m_pend[i] = 0; end
    m_valid = 0; m_opA = 0; m_opB = 0; m_dest = 0; m_dw = 0; m_stall = 0;
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_plain_read();
    test_bypass();
    test_raw_stall();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
